// File: rtl/pipe_seg_reg.sv
// pipe_seg_reg: registered pipeline segment with valid/ready handshakes.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side. A producer holds valid and data stable until the
// transfer. Neither valid nor data may depend on ready in the same cycle.
//
// Per-edge priority: resetn (sync, active-low) > refresh > stall > transfer.
// refresh empties the stage, reloads payloads with NOP_VAL and drops any
// simultaneous input. stall blocks both sides combinationally and freezes all
// state. While stalled, out_data keeps showing the head payload.
//
// Build option: define PIPE_SEG_SKID_EN for a two-entry stage (head + skid).
// In that build in_ready comes only from registers, which cuts the
// out_ready -> in_ready path. Without the macro the stage has one entry and
// in_ready depends combinationally on out_ready.
module pipe_seg_reg #(
  parameter int unsigned   DW      = 32,
  parameter logic [DW-1:0] NOP_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          stall,
  input  logic          refresh,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occ
);

  logic          head_valid_q, head_valid_d;
  logic [DW-1:0] head_data_q,  head_data_d;
  logic          in_fire;
  logic          out_fire;

`ifdef PIPE_SEG_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;

  // Ready depends only on the skid flag, so it carries no out_ready path.
  always_comb begin
    in_ready  = !skid_valid_q && !stall && resetn;
    out_valid = head_valid_q && !stall;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    occ       = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
  end

  // Next-state for the head/skid pair. When the head drains, the skid refills
  // it; otherwise the incoming payload does.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (refresh) begin
      head_valid_d = 1'b0;
      head_data_d  = NOP_VAL;
      skid_valid_d = 1'b0;
      skid_data_d  = NOP_VAL;
    end else if (!stall) begin
      if (out_fire) begin
        if (skid_valid_q) begin
          // in_ready is low whenever skid is valid, so no input competes here.
          head_valid_d = 1'b1;
          head_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          head_valid_d = 1'b1;
          head_data_d  = in_data;
        end else begin
          head_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (!head_valid_q) begin
          head_valid_d = 1'b1;
          head_data_d  = in_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VAL;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Single entry: the stage can accept while empty, or while its head leaves.
  always_comb begin
    in_ready  = (!head_valid_q || out_ready) && !stall && resetn;
    out_valid = head_valid_q && !stall;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    occ       = {1'b0, head_valid_q};
  end

  // Next-state for the single head entry.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    if (refresh) begin
      head_valid_d = 1'b0;
      head_data_d  = NOP_VAL;
    end else if (!stall) begin
      if (in_fire) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
      end else if (out_fire) begin
        head_valid_d = 1'b0;
      end
    end
  end
`endif

  // Head entry registers. out_data is taken straight from these flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_valid_q <= 1'b0;
      head_data_q  <= NOP_VAL;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign out_data = head_data_q;

endmodule
